zbb_wb_stage: RTL and testbench

EX/WB pipeline stage directly downstream of the Zbb bit-manipulation unit and the base ALU. Merges the two result streams into one write-back entry and buffers it in a 2-entry skid FIFO (valid/ready) in front of the register-file write port. Provides forwarding of buffered results to the decode stage and a retired-Zbb-instruction counter.

---
 rtl/zbb_wb_stage_pkg.sv | 34 +++
 rtl/zbb_wb_stage_if.sv | 47 ++++
 rtl/wb_skid_buf.sv | 83 ++++++++
 rtl/zbb_wb_stage.sv | 108 ++++++++++
 tb/tb_zbb_wb_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zbb_wb_stage_pkg.sv
// Shared types for the Zbb/ALU write-back stage: datapath widths, the
// write-back entry layout and the forwarding match rule.
package zbb_wb_stage_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   // Fields decode needs for forwarding; kept at the top of the payload so the
   // skid buffer can expose them as a plain bit slice.
   typedef struct packed {
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    data;
      logic               we;
   } fwd_view_t;

   typedef struct packed {
      fwd_view_t fv;
      logic      zflag;
   } wb_payload_t;

   typedef struct packed {
      logic        valid;
      wb_payload_t pl;
   } wb_entry_t;

   localparam int PAYLOAD_W = $bits(wb_payload_t);
   localparam int VIEW_W    = $bits(fwd_view_t);

   function automatic logic fwd_match(input logic valid, input fwd_view_t v,
                                      input logic [RADDR_W-1:0] rs);
      return valid && v.we && (v.rd == rs) && (rs != {RADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/zbb_wb_stage_if.sv
// Bus bundle between the EX producers, the register-file write port and the
// decode forwarding lookups of the write-back stage.
interface zbb_wb_stage_if #(
   parameter int CNT_W = 32
) ();
   import zbb_wb_stage_pkg::*;

   logic               flush;
   logic               cnt_clr;
   logic               ex_valid;
   logic               ex_ready;
   logic [RADDR_W-1:0] ex_rd;
   logic [XLEN-1:0]    alu_result;
   logic               alu_reg_write;
   logic [XLEN-1:0]    zbb_result;
   logic               zbb_is_instr;
   logic               zbb_reg_write;
   logic               wb_valid;
   logic               wb_ready;
   logic [RADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]    wb_data;
   logic               wb_we;
   logic [RADDR_W-1:0] fwd_rs1_addr;
   logic [RADDR_W-1:0] fwd_rs2_addr;
   logic               fwd_rs1_hit;
   logic [XLEN-1:0]    fwd_rs1_data;
   logic               fwd_rs2_hit;
   logic [XLEN-1:0]    fwd_rs2_data;
   logic [CNT_W-1:0]   zbb_retired;

   modport slave (
      input  flush, cnt_clr, ex_valid, ex_rd, alu_result, alu_reg_write,
             zbb_result, zbb_is_instr, zbb_reg_write, wb_ready,
             fwd_rs1_addr, fwd_rs2_addr,
      output ex_ready, wb_valid, wb_rd, wb_data, wb_we,
             fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data, zbb_retired
   );

   modport master (
      output flush, cnt_clr, ex_valid, ex_rd, alu_result, alu_reg_write,
             zbb_result, zbb_is_instr, zbb_reg_write, wb_ready,
             fwd_rs1_addr, fwd_rs2_addr,
      input  ex_ready, wb_valid, wb_rd, wb_data, wb_we,
             fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data, zbb_retired
   );

endinterface

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (head + skid) with a registered
// ready, a synchronous flush and a peek port onto the skid entry.
module wb_skid_buf #(
   parameter int W      = 8,
   parameter int PEEK_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [W-1:0]      in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [W-1:0]      out_data_o,
   output logic              skid_valid_o,
   output logic [PEEK_W-1:0] skid_peek_o,
   output logic              pop_o
);

   logic         head_valid_q, head_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] head_data_q, head_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         ready_q, ready_d;
   logic         accept_s, pop_s;

   assign accept_s = in_valid_i & ready_q;
   assign pop_s    = head_valid_q & out_ready_i;

   // Next-state for head/skid; skid is only ever valid while head is valid.
   always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (pop_s && skid_valid_q) begin
         head_data_d  = skid_data_q;
         skid_valid_d = accept_s;
         skid_data_d  = in_data_i;
      end else if (pop_s) begin
         head_valid_d = accept_s;
         head_data_d  = in_data_i;
      end else if (accept_s && !head_valid_q) begin
         head_valid_d = 1'b1;
         head_data_d  = in_data_i;
      end else if (accept_s) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end else begin
         head_valid_d = head_valid_q;
      end
      ready_d = ~skid_valid_d;
   end

   // Storage and registered ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         head_data_q  <= {W{1'b0}};
         skid_data_q  <= {W{1'b0}};
         ready_q      <= 1'b1;
      end else begin
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         head_data_q  <= head_data_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready_o   = ready_q;
   assign out_valid_o  = head_valid_q;
   assign out_data_o   = head_data_q;
   assign skid_valid_o = skid_valid_q;
   assign skid_peek_o  = skid_data_q[W-1 -: PEEK_W];
   assign pop_o        = pop_s;

endmodule

// File: rtl/zbb_wb_stage.sv
// EX/WB stage: merges the Zbb and ALU results, buffers them in a skid buffer,
// forwards buffered values to decode and counts retired Zbb entries.
module zbb_wb_stage
   import zbb_wb_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic           clk,
   input logic           rst,
   zbb_wb_stage_if.slave bus
);

   wb_payload_t          in_pl_s;
   wb_payload_t          head_pl_s;
   fwd_view_t            skid_fv_s;
   logic [PAYLOAD_W-1:0] head_vec_s;
   logic [VIEW_W-1:0]    skid_vec_s;
   logic                 head_v_s, skid_v_s, pop_s, raw_we_s;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Result merge; rd==0 never writes but the Zbb tag is kept for retirement.
   always_comb begin
      in_pl_s.fv.rd = bus.ex_rd;
      if (bus.zbb_is_instr) begin
         in_pl_s.fv.data = bus.zbb_result;
         raw_we_s        = bus.zbb_reg_write;
         in_pl_s.zflag   = 1'b1;
      end else begin
         in_pl_s.fv.data = bus.alu_result;
         raw_we_s        = bus.alu_reg_write;
         in_pl_s.zflag   = 1'b0;
      end
      in_pl_s.fv.we = raw_we_s & (|bus.ex_rd);
   end

   wb_skid_buf #(
      .W      (PAYLOAD_W),
      .PEEK_W (VIEW_W)
   ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (bus.flush),
      .in_valid_i   (bus.ex_valid),
      .in_ready_o   (bus.ex_ready),
      .in_data_i    (in_pl_s),
      .out_valid_o  (head_v_s),
      .out_ready_i  (bus.wb_ready),
      .out_data_o   (head_vec_s),
      .skid_valid_o (skid_v_s),
      .skid_peek_o  (skid_vec_s),
      .pop_o        (pop_s)
   );

   assign head_pl_s = wb_payload_t'(head_vec_s);
   assign skid_fv_s = fwd_view_t'(skid_vec_s);

   assign bus.wb_valid = head_v_s;
   assign bus.wb_rd    = head_v_s ? head_pl_s.fv.rd   : {RADDR_W{1'b0}};
   assign bus.wb_data  = head_v_s ? head_pl_s.fv.data : {XLEN{1'b0}};
   assign bus.wb_we    = head_v_s & head_pl_s.fv.we;

   // Forwarding lookup: the skid entry is younger, so it wins over head.
   always_comb begin
      if (fwd_match(skid_v_s, skid_fv_s, bus.fwd_rs1_addr)) begin
         bus.fwd_rs1_hit  = 1'b1;
         bus.fwd_rs1_data = skid_fv_s.data;
      end else if (fwd_match(head_v_s, head_pl_s.fv, bus.fwd_rs1_addr)) begin
         bus.fwd_rs1_hit  = 1'b1;
         bus.fwd_rs1_data = head_pl_s.fv.data;
      end else begin
         bus.fwd_rs1_hit  = 1'b0;
         bus.fwd_rs1_data = {XLEN{1'b0}};
      end
      if (fwd_match(skid_v_s, skid_fv_s, bus.fwd_rs2_addr)) begin
         bus.fwd_rs2_hit  = 1'b1;
         bus.fwd_rs2_data = skid_fv_s.data;
      end else if (fwd_match(head_v_s, head_pl_s.fv, bus.fwd_rs2_addr)) begin
         bus.fwd_rs2_hit  = 1'b1;
         bus.fwd_rs2_data = head_pl_s.fv.data;
      end else begin
         bus.fwd_rs2_hit  = 1'b0;
         bus.fwd_rs2_data = {XLEN{1'b0}};
      end
   end

   // Retired-Zbb counter next state; a flushed pop still counts.
   always_comb begin
      if (bus.cnt_clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (pop_s && head_pl_s.zflag) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Retired-Zbb counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.zbb_retired = cnt_q;

endmodule

// File: tb/tb_zbb_wb_stage.sv
// Self-checking bench for zbb_wb_stage: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_zbb_wb_stage;

   localparam int TW   = 6;
   localparam int CMOD = 1 << TW;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        z;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t mq[$];
   int   mcnt = 0;
   logic [111:0] act_vec;

   zbb_wb_stage_if #(.CNT_W(TW)) bus ();
   zbb_wb_stage #(.CNT_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   assign act_vec = {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_we, bus.ex_ready,
                     bus.fwd_rs1_hit, bus.fwd_rs1_data, bus.fwd_rs2_hit, bus.fwd_rs2_data,
                     bus.zbb_retired};

   function automatic ent_t model_entry();
      ent_t e;
      e.rd   = bus.ex_rd;
      e.z    = bus.zbb_is_instr;
      e.data = bus.zbb_is_instr ? bus.zbb_result : bus.alu_result;
      e.we   = (bus.ex_rd != 5'd0) && (bus.zbb_is_instr ? bus.zbb_reg_write : bus.alu_reg_write);
      return e;
   endfunction

   // Youngest buffered writer of rs wins.
   function automatic void exp_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = 32'd0;
      if (rs != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i].we && mq[i].rd == rs) begin
               hit = 1'b1;
               d   = mq[i].data;
            end
         end
      end
   endfunction

   function automatic logic [111:0] exp_vec();
      logic h1, h2;
      logic [31:0] d1, d2;
      ent_t hd;
      logic [TW-1:0] c;
      hd = '0;
      if (mq.size() > 0) hd = mq[0];
      exp_fwd(bus.fwd_rs1_addr, h1, d1);
      exp_fwd(bus.fwd_rs2_addr, h2, d2);
      c = mcnt[TW-1:0];
      return {mq.size() > 0, hd.rd, hd.data, hd.we, mq.size() < 2, h1, d1, h2, d2, c};
   endfunction

   task automatic set_idle();
      bus.flush = 1'b0; bus.cnt_clr = 1'b0; bus.ex_valid = 1'b0; bus.ex_rd = 5'd0;
      bus.alu_result = 32'd0; bus.alu_reg_write = 1'b0; bus.zbb_result = 32'd0;
      bus.zbb_is_instr = 1'b0; bus.zbb_reg_write = 1'b0; bus.wb_ready = 1'b0;
      bus.fwd_rs1_addr = 5'd0; bus.fwd_rs2_addr = 5'd0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
      bus.ex_valid = 1'b1; bus.zbb_is_instr = 1'b0; bus.ex_rd = rd;
      bus.alu_result = d; bus.alu_reg_write = 1'b1; bus.zbb_result = $urandom;
      bus.zbb_reg_write = 1'b1;
   endtask

   task automatic drive_zbb(input logic [4:0] rd, input logic [31:0] d, input logic we);
      bus.ex_valid = 1'b1; bus.zbb_is_instr = 1'b1; bus.ex_rd = rd;
      bus.zbb_result = d; bus.zbb_reg_write = we; bus.alu_result = $urandom;
      bus.alu_reg_write = 1'b1;
   endtask

   // Advance one clock and apply the same transfer to the model.
   task automatic tick();
      logic acc, pop;
      ent_t e, h;
      acc = bus.ex_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && bus.wb_ready;
      e   = model_entry();
      h   = '0;
      @(posedge clk);
      if (pop) h = mq.pop_front();
      if (acc) mq.push_back(e);
      if (bus.flush) mq.delete();
      if (bus.cnt_clr) mcnt = 0;
      else if (pop && h.z) mcnt = (mcnt + 1) % CMOD;
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec());
      end
      n_checks++;
      if ({bus.wb_valid, bus.ex_ready, bus.wb_data, bus.zbb_retired} !== {1'b0, 1'b1, 32'd0, 6'd0}) begin
         n_fail++; $display("FAIL reset_values: valid=%b ready=%b data=%h cnt=%0d",
                            bus.wb_valid, bus.ex_ready, bus.wb_data, bus.zbb_retired);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zbb_basic();
      drive_zbb(5'd5, 32'h0000_001A, 1'b1);
      tick();
      bus.ex_valid = 1'b0; bus.wb_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_we} !== {1'b1, 5'd5, 32'h1A, 1'b1}) begin
         n_fail++; $display("FAIL zbb_head: got v=%b rd=%0d d=%h we=%b expected 1/5/1a/1",
                            bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_we);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (bus.zbb_retired !== 6'd1 || bus.wb_valid !== 1'b0) begin
         n_fail++; $display("FAIL zbb_retire: got cnt=%0d valid=%b expected 1/0", bus.zbb_retired, bus.wb_valid);
      end
      set_idle(); tick();
   endtask

   task automatic test_stall();
      logic [31:0] got[$];
      logic acc;
      drive_alu(5'd1, 32'h11); tick();
      drive_alu(5'd2, 32'h22);
      @(negedge clk);
      n_checks++;
      if (bus.ex_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_ready1: got %b expected 1", bus.ex_ready);
      end
      tick();
      drive_alu(5'd3, 32'h33);
      @(negedge clk);
      n_checks++;
      if (bus.ex_ready !== 1'b0 || bus.wb_data !== 32'h11) begin
         n_fail++; $display("FAIL stall_full: got ready=%b data=%h expected 0/11", bus.ex_ready, bus.wb_data);
      end
      tick();
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL stall_drain: got %h expected %h", act_vec, exp_vec());
         end
         if (bus.wb_valid) got.push_back(bus.wb_data);
         acc = bus.ex_valid && bus.ex_ready;
         tick();
         if (acc) bus.ex_valid = 1'b0;
      end
      n_checks++;
      if (got.size() != 3 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33) begin
         n_fail++; $display("FAIL stall_order: got %0d entries expected 11,22,33", got.size());
      end
      set_idle(); tick();
   endtask

   task automatic test_forward();
      drive_alu(5'd7, 32'hAAAA); tick();
      drive_alu(5'd7, 32'hBBBB); tick();
      bus.ex_valid = 1'b0; bus.fwd_rs1_addr = 5'd7; bus.fwd_rs2_addr = 5'd0;
      @(negedge clk);
      n_checks++;
      if ({bus.fwd_rs1_hit, bus.fwd_rs1_data, bus.fwd_rs2_hit, bus.fwd_rs2_data} !==
          {1'b1, 32'hBBBB, 1'b0, 32'd0}) begin
         n_fail++; $display("FAIL fwd_priority: got rs1 %b/%h rs2 %b/%h expected 1/bbbb 0/0",
                            bus.fwd_rs1_hit, bus.fwd_rs1_data, bus.fwd_rs2_hit, bus.fwd_rs2_data);
      end
      bus.wb_ready = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
         n_fail++; $display("FAIL fwd_after_pop: got %h expected %h", act_vec, exp_vec());
      end
      tick();
      set_idle(); tick();
   endtask

   task automatic test_rd0();
      int c0;
      c0 = mcnt;
      drive_zbb(5'd0, $urandom, 1'b1); tick();
      bus.ex_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.wb_valid, bus.wb_we, bus.fwd_rs1_hit, bus.fwd_rs2_hit} !== 4'b1000) begin
         n_fail++; $display("FAIL rd0_we: got v=%b we=%b h1=%b h2=%b expected 1/0/0/0",
                            bus.wb_valid, bus.wb_we, bus.fwd_rs1_hit, bus.fwd_rs2_hit);
      end
      bus.wb_ready = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if (bus.zbb_retired !== 6'((c0 + 1) % CMOD)) begin
         n_fail++; $display("FAIL rd0_count: got %0d expected %0d", bus.zbb_retired, (c0 + 1) % CMOD);
      end
      set_idle(); tick();
   endtask

   task automatic test_flush();
      int c0;
      drive_alu(5'd4, 32'h44); tick();
      drive_zbb(5'd6, 32'h66, 1'b1); tick();
      drive_alu(5'd8, 32'h88); bus.flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.ex_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_pre: got ready=%b expected 0", bus.ex_ready);
      end
      tick();
      bus.flush = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.wb_valid !== 1'b0 || bus.ex_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_clear: got valid=%b ready=%b expected 0/1", bus.wb_valid, bus.ex_ready);
      end
      bus.wb_ready = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
         n_fail++; $display("FAIL flush_empty: got %h expected %h", act_vec, exp_vec());
      end
      bus.wb_ready = 1'b0;
      drive_zbb(5'd9, 32'h99, 1'b1); tick();
      c0 = mcnt;
      drive_alu(5'd10, 32'hA0); bus.wb_ready = 1'b1; bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.wb_valid !== 1'b0 || bus.zbb_retired !== 6'((c0 + 1) % CMOD)) begin
         n_fail++; $display("FAIL flush_pop_count: got valid=%b cnt=%0d expected 0/%0d",
                            bus.wb_valid, bus.zbb_retired, (c0 + 1) % CMOD);
      end
      set_idle(); tick();
   endtask

   task automatic test_counter_wrap();
      drive_zbb(5'd1, 32'h5, 1'b1); bus.wb_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (mcnt == CMOD - 1) break;
         bus.ex_valid = (mcnt + mq.size()) < (CMOD - 1);
         tick();
      end
      bus.ex_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.zbb_retired !== 6'h3F) begin
         n_fail++; $display("FAIL cnt_max: got %0d expected 63", bus.zbb_retired);
      end
      drive_zbb(5'd2, 32'h6, 1'b1); bus.wb_ready = 1'b0; tick();
      bus.ex_valid = 1'b0; bus.wb_ready = 1'b1; tick();
      @(negedge clk);
      n_checks++;
      if (bus.zbb_retired !== 6'd0) begin
         n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", bus.zbb_retired);
      end
      drive_zbb(5'd3, 32'h7, 1'b1); bus.wb_ready = 1'b0; tick();
      bus.ex_valid = 1'b0; bus.wb_ready = 1'b1; tick();
      drive_zbb(5'd3, 32'h8, 1'b1); bus.wb_ready = 1'b0; tick();
      bus.ex_valid = 1'b0; bus.wb_ready = 1'b1; bus.cnt_clr = 1'b1; tick();
      bus.cnt_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.zbb_retired !== 6'd0 || act_vec !== exp_vec()) begin
         n_fail++; $display("FAIL cnt_clr_prio: got cnt=%0d expected 0", bus.zbb_retired);
      end
      set_idle(); tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.ex_valid      = ($urandom % 4) != 0;
         bus.ex_rd         = 5'($urandom % 8);
         bus.alu_result    = $urandom;
         bus.zbb_result    = $urandom;
         bus.alu_reg_write = 1'($urandom % 2);
         bus.zbb_reg_write = 1'($urandom % 2);
         bus.zbb_is_instr  = 1'($urandom % 2);
         bus.wb_ready      = ($urandom % 3) != 0;
         bus.fwd_rs1_addr  = 5'($urandom % 8);
         bus.fwd_rs2_addr  = 5'($urandom % 8);
         bus.flush         = ($urandom % 32) == 0;
         bus.cnt_clr       = ($urandom % 32) == 0;
         @(negedge clk);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec());
         end
         tick();
      end
      set_idle(); tick();
   endtask

   task automatic test_async_reset();
      drive_zbb(5'd11, 32'hB0, 1'b1); tick();
      drive_alu(5'd12, 32'hC0); tick();
      set_idle();
      #2;
      rst = 1'b1;
      #1;
      mq.delete(); mcnt = 0;
      n_checks++;
      if ({bus.wb_valid, bus.ex_ready, bus.wb_data, bus.zbb_retired} !== {1'b0, 1'b1, 32'd0, 6'd0}) begin
         n_fail++; $display("FAIL async_reset: valid=%b ready=%b data=%h cnt=%0d",
                            bus.wb_valid, bus.ex_ready, bus.wb_data, bus.zbb_retired);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_zbb_basic();
      test_stall();
      test_forward();
      test_rd0();
      test_flush();
      test_counter_wrap();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
